// File: rtl/regfile_pkg.sv
// Shared widths, register typedefs and the hard-wired zero register index
// for the scoreboarded register file.
package regfile_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;
    typedef logic [ADDR_WIDTH_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: issue sets, writeback clears, set wins on collision.
// pend_cnt is the registered population count of the pending bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_WR     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]  wr_addr,
    output logic [2**ADDR_WIDTH-1:0]      pending,
    output logic [ADDR_WIDTH:0]           pend_cnt
);

    logic [2**ADDR_WIDTH-1:0] pend_nxt;
    logic [ADDR_WIDTH:0]      cnt_nxt;

    // Clears first, then the issue set overrides them.
    always_comb begin
        pend_nxt = pending;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                pend_nxt[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (iss_valid && iss_rd != ADDR_WIDTH'(REG_ZERO)) begin
            pend_nxt[iss_rd] = 1'b1;
        end
        cnt_nxt = '0;
        for (int r = 0; r < 2**ADDR_WIDTH; r++) begin
            cnt_nxt = cnt_nxt + (ADDR_WIDTH+1)'(pend_nxt[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with issue/writeback scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]             rd_pend,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  wr_data,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    output logic                          stall,
    output logic [ADDR_WIDTH:0]           pend_cnt,
    input  logic [ADDR_WIDTH-1:0]         dbg_addr,
    output logic [DATA_WIDTH-1:0]         dbg_data
);

    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0]    regs [2**ADDR_WIDTH];
    logic [2**ADDR_WIDTH-1:0] pending;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_WR     (NUM_WR)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .pending   (pending),
        .pend_cnt  (pend_cnt)
    );

    // Later ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 2**ADDR_WIDTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != ZERO) begin
                    regs[wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        stall   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO) begin
                rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    regs[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                rd_pend[i] = pending[rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                        rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                        rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                            wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                        rd_pend[i] = 1'b0;
                    end
                end
`endif
            end
            stall = stall | rd_pend[i];
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, register address width (2**ADDR_WIDTH registers).
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 The block SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port rd_addr, input, NUM_RD*ADDR_WIDTH bits, read addresses; port i is slice i.
REQ-008 The block SHALL have port rd_data, output, NUM_RD*DATA_WIDTH bits, read data per port.
REQ-009 The block SHALL have port rd_pend, output, NUM_RD bits, scoreboard pending flag for each read address.
REQ-010 The block SHALL have ports wr_en (NUM_WR), wr_addr (NUM_WR*ADDR_WIDTH) and wr_data (NUM_WR*DATA_WIDTH), all inputs: writeback ports.
REQ-011 The block SHALL have ports iss_valid (1) and iss_rd (ADDR_WIDTH), both inputs: the issue marks iss_rd pending.
REQ-012 The block SHALL have port stall, output, 1 bit, high when any read port with a nonzero address is pending and not resolved this cycle.
REQ-013 The block SHALL have port pend_cnt, output, ADDR_WIDTH+1 bits, registered count of pending registers.
REQ-014 The block SHALL have port dbg_addr, input, ADDR_WIDTH bits, and port dbg_data, output, DATA_WIDTH bits, a combinational debug read of the stored value with no bypass.

Function
REQ-015 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never become pending.
REQ-016 rd_data SHALL be combinational from rd_addr (zero-cycle read latency).
REQ-017 Writes SHALL commit on the posedge of clk, so a value is visible in the stored array on the next cycle.
REQ-018 When multiple wr_en hit the same address in one cycle, the highest-index port SHALL win.
REQ-019 pending[r] SHALL be set on the posedge with iss_valid and iss_rd==r, and cleared on the posedge of any wr_en to r.
REQ-020 When a pending register is issued and written back in the same cycle, set SHALL win and pending SHALL remain 1.
REQ-021 rd_pend[i] SHALL equal pending[rd_addr[i]], except that it SHALL be 0 when REGFILE_BYPASS_EN resolves the read from a same-cycle write.
REQ-022 pend_cnt SHALL equal the population count of pending after each edge, and SHALL saturate at neither end because it is bounded by construction, with maximum 2**ADDR_WIDTH-1.
REQ-023 A write to a register that is not pending SHALL be legal and SHALL update the data without changing the scoreboard.

Reset
REQ-024 On rst_n low, all registers SHALL clear to 0 asynchronously.
REQ-025 On rst_n low, the pending bits SHALL clear to 0 and pend_cnt SHALL be 0, so stall is 0.
REQ-026 Writes or issues in flight during reset SHALL be discarded.
REQ-027 The first state update after reset SHALL occur on the first posedge with rst_n high.

Configuration
REQ-028 With macro REGFILE_BYPASS_EN defined, rd_data SHALL return wr_data of the winning same-cycle writer whose wr_addr matches rd_addr (nonzero), and the matching rd_pend SHALL be cleared.
REQ-029 Without REGFILE_BYPASS_EN, rd_data SHALL be the stored value only, and rd_pend SHALL reflect pending before the edge.

Structure
REQ-030 Package regfile_pkg SHALL hold the default width constants, the reg_addr_t/reg_data_t typedefs, and the REG_ZERO constant.
REQ-031 A sub-module regfile_scoreboard SHALL hold the pending bits, the set/clear priority, and pend_cnt; the data array and bypass muxes SHALL stay at top level.

Verification
REQ-032 Reset check: hold rst_n low mid-run after writes, release it, then read x5 -> 0, pend_cnt=0, stall=0.
REQ-033 Write then read: write port0 x3=0xDEADBEEF, then read x3 the next cycle -> 0xDEADBEEF; a write to x0=0x1 -> x0 reads 0.
REQ-034 Write collision: wr0 and wr1 both write x7 (0x11, 0x22) -> x7=0x22.
REQ-035 Scoreboard: issue x9, then read x9 -> rd_pend=1, stall=1, pend_cnt=1; write x9=0x5 -> the next cycle pend=0 and pend_cnt=0.
REQ-036 Set/clear collision: x9 is pending, then iss_rd=9 and a wr to x9 occur in the same cycle -> x9 stays pending and pend_cnt is unchanged.
REQ-037 Bypass, with REGFILE_BYPASS_EN: x4 is pending, then wr x4=0xABCD while reading x4 -> rd_data=0xABCD, rd_pend=0, stall=0; without the macro -> the old value is returned and stall=1.
